// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types, constants and helpers for the bus arbiter
//
// Contents:
//   state_t    arbiter FSM states (IDLE, GRANT, HOLD)
//   DATA_W     width of the shared writer data bus
//   ptr_width  bits needed to index n items (minimum 1)
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DATA_W = 8;

    // Width of an index into n items. Never returns 0, so a one-bit
    // pointer still exists for the smallest configurations.
    function automatic int ptr_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/arbiter_rr_priority.sv
// rtl/arbiter_rr_priority.sv - combinational round-robin winner search
//
// Ports:
//   req     in   N   request vector, one bit per client
//   ptr     in   PW  index where the search starts (highest priority)
//   winner  out  PW  first requesting index at or above ptr, wrapping
//   any     out  1   at least one request is set; winner valid only then
module rr_priority
    import arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          any
);

    logic [PW-1:0] idx;

    // Walk offsets from the farthest to the nearest so that the last hit
    // written is the one closest to ptr, i.e. the highest priority one.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = PW'((int'(ptr) + off) % N);
            if (req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter.sv
// rtl/arbiter.sv - round-robin arbiter for writers sharing one 8-bit bus
//
// Ports:
//   i_clk     in   1          clock, rising edge
//   i_reset   in   1          asynchronous active-high reset
//   i_req     in   N_WRITERS  per-writer request, held until granted
//   i_data    in   8          shared bus, driven by the granted writer
//   o_busy    out  N_WRITERS  low bit = that writer owns the bus this cycle
//   o_data    out  8          last captured transfer
//   o_valid   out  1          one-cycle pulse, o_data/o_source fresh
//   o_source  out  PW         writer index that produced o_data
//   o_err     out  1          one-cycle pulse, granted writer withdrew
//
// Each transfer occupies IDLE (arbitrate), GRANT (bus owned, capture at
// end of cycle) and HOLD_CYCLES of HOLD (bus quiet for turnaround), so
// the grant period is 2 + HOLD_CYCLES cycles.
module arbiter
    import arbiter_pkg::*;
#(
    parameter int N_WRITERS   = 4,
    parameter int HOLD_CYCLES = 2,
    localparam int PW = ptr_width(N_WRITERS),
    localparam int HW = ptr_width(HOLD_CYCLES + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_WRITERS-1:0] i_req,
    input  logic [DATA_W-1:0]    i_data,
    output logic [N_WRITERS-1:0] o_busy,
    output logic [DATA_W-1:0]    o_data,
    output logic                 o_valid,
    output logic [PW-1:0]        o_source,
    output logic                 o_err
);

    localparam logic [N_WRITERS-1:0] ONE_HOT0 = N_WRITERS'(1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [HW-1:0] hold_cnt;

    logic [PW-1:0] sel;
    logic          sel_any;
    logic [PW-1:0] next_ptr;

    rr_priority #(
        .N (N_WRITERS)
    ) u_rr (
        .req    (i_req),
        .ptr    (ptr),
        .winner (sel),
        .any    (sel_any)
    );

    // Pointer moves one past the last winner whether or not it delivered,
    // so a writer that withdraws cannot starve the others.
    assign next_ptr = (win == PW'(N_WRITERS - 1)) ? '0 : win + PW'(1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            hold_cnt <= '0;
            o_busy   <= '1;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_source <= '0;
            o_err    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        state  <= GRANT;
                        win    <= sel;
                        o_busy <= ~(ONE_HOT0 << sel);
                    end
                end
                GRANT: begin
                    // The winner still requesting means it is driving the
                    // bus this cycle; otherwise the grant was wasted.
                    if (i_req[win]) begin
                        o_data   <= i_data;
                        o_source <= win;
                        o_valid  <= 1'b1;
                    end else begin
                        o_err <= 1'b1;
                    end
                    o_busy   <= '1;
                    ptr      <= next_ptr;
                    state    <= HOLD;
                    hold_cnt <= HW'(HOLD_CYCLES);
                end
                HOLD: begin
                    if (hold_cnt <= HW'(1)) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= '1;
                end
            endcase
        end
    end

    a_state_bounded : assert property (@(posedge i_clk) disable iff (i_reset)
        state inside {IDLE, GRANT, HOLD});

    a_one_owner : assert property (@(posedge i_clk) disable iff (i_reset)
        $countones(~o_busy) <= 1);

    a_busy_single_cycle : assert property (@(posedge i_clk) disable iff (i_reset)
        (o_busy != '1) |=> (o_busy == '1));

    a_valid_after_grant : assert property (@(posedge i_clk) disable iff (i_reset)
        o_valid |-> ($past(state) == GRANT));

    a_pulses_exclusive : assert property (@(posedge i_clk) disable iff (i_reset)
        !(o_valid && o_err));

endmodule

// File: tb/tb_arbiter.sv
// tb/tb_arbiter.sv - directed self-checking bench for arbiter (4 writers, hold 2)
module tb_arbiter;

    logic       i_clk;
    logic       i_reset;
    logic [3:0] i_req;
    logic [7:0] i_data;
    logic [3:0] o_busy;
    logic [7:0] o_data;
    logic       o_valid;
    logic [1:0] o_source;
    logic       o_err;

    int checks;
    int errors;

    arbiter #(
        .N_WRITERS   (4),
        .HOLD_CYCLES (2)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_req    (i_req),
        .i_data   (i_data),
        .o_busy   (o_busy),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_source (o_source),
        .o_err    (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_req   = 4'b0000;
        i_data  = 8'h00;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_req   = 4'b0000;
        i_data  = 8'h00;
        #1;
        checks++; if (o_busy !== 4'b1111) begin errors++; $display("FAIL reset_busy got %b exp 1111", o_busy); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", o_data); end
        checks++; if (o_valid !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got v=%b e=%b exp 0 0", o_valid, o_err); end
        checks++; if (o_source !== 2'd0) begin errors++; $display("FAIL reset_source got %0d exp 0", o_source); end
        do_reset();
        tick();
        checks++; if (o_busy !== 4'b1111) begin errors++; $display("FAIL idle_no_req got %b exp 1111", o_busy); end
    endtask

    task automatic test_single();
        do_reset();
        i_req = 4'b0100;
        tick();
        checks++; if (o_busy !== 4'b1011) begin errors++; $display("FAIL single_busy got %b exp 1011", o_busy); end
        i_data = 8'h05;
        tick();
        i_req  = 4'b0000;
        i_data = 8'h00;
        checks++; if (o_valid !== 1'b1 || o_data !== 8'h05 || o_source !== 2'd2) begin
            errors++; $display("FAIL single_xfer got v=%b d=%h s=%0d exp 1 05 2", o_valid, o_data, o_source);
        end
        checks++; if (o_busy !== 4'b1111) begin errors++; $display("FAIL single_release got %b exp 1111", o_busy); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_data !== 8'h05) begin
            errors++; $display("FAIL single_hold_data got v=%b d=%h exp 0 05", o_valid, o_data);
        end
        tick();
        tick();
        checks++; if (o_busy !== 4'b1111 || o_source !== 2'd2) begin
            errors++; $display("FAIL single_idle got b=%b s=%0d exp 1111 2", o_busy, o_source);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_busy;
        do_reset();
        i_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_busy = ~(4'b0001 << (g % 4));
            tick();
            checks++; if (o_busy !== exp_busy) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", g, o_busy, exp_busy); end
            i_data = 8'hA0 + 8'(g);
            tick();
            checks++; if (o_valid !== 1'b1 || o_source !== 2'(g % 4) || o_data !== 8'hA0 + 8'(g)) begin
                errors++; $display("FAIL rr_xfer%0d got v=%b s=%0d d=%h exp 1 %0d %h", g, o_valid, o_source, o_data, g % 4, 8'hA0 + 8'(g));
            end
            tick();
            tick();
            checks++; if (o_busy !== 4'b1111) begin errors++; $display("FAIL rr_gap%0d got %b exp 1111", g, o_busy); end
        end
        i_req = 4'b0000;
    endtask

    task automatic test_pointer_wrap();
        int order [4] = '{3, 0, 3, 0};
        logic [3:0] exp_busy;
        do_reset();
        i_req = 4'b0001;
        tick();
        checks++; if (o_busy !== 4'b1110) begin errors++; $display("FAIL wrap_setup got %b exp 1110", o_busy); end
        tick();
        tick();
        tick();
        i_req = 4'b1001;
        for (int g = 0; g < 4; g++) begin
            exp_busy = ~(4'b0001 << order[g]);
            tick();
            checks++; if (o_busy !== exp_busy) begin errors++; $display("FAIL wrap_grant%0d got %b exp %b", g, o_busy, exp_busy); end
            tick();
            checks++; if (o_source !== 2'(order[g])) begin errors++; $display("FAIL wrap_src%0d got %0d exp %0d", g, o_source, order[g]); end
            tick();
            tick();
        end
        i_req = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        i_req = 4'b0010;
        tick();
        checks++; if (o_busy !== 4'b1101) begin errors++; $display("FAIL midrst_grant got %b exp 1101", o_busy); end
        #2;
        i_reset = 1'b1;
        #1;
        checks++; if (o_busy !== 4'b1111) begin errors++; $display("FAIL midrst_async got %b exp 1111", o_busy); end
        i_req = 4'b0011;
        tick();
        checks++; if (o_valid !== 1'b0 || o_err !== 1'b0 || o_busy !== 4'b1111) begin
            errors++; $display("FAIL midrst_quiet got v=%b e=%b b=%b exp 0 0 1111", o_valid, o_err, o_busy);
        end
        i_reset = 1'b0;
        tick();
        checks++; if (o_busy !== 4'b1110) begin errors++; $display("FAIL midrst_first got %b exp 1110", o_busy); end
        i_req = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_withdraw();
        do_reset();
        i_req = 4'b0010;
        tick();
        checks++; if (o_busy !== 4'b1101) begin errors++; $display("FAIL wd_grant got %b exp 1101", o_busy); end
        i_req = 4'b0000;
        tick();
        checks++; if (o_err !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL wd_err got e=%b v=%b exp 1 0", o_err, o_valid);
        end
        i_req = 4'b1111;
        tick();
        checks++; if (o_err !== 1'b0 || o_busy !== 4'b1111) begin
            errors++; $display("FAIL wd_hold got e=%b b=%b exp 0 1111", o_err, o_busy);
        end
        tick();
        tick();
        checks++; if (o_busy !== 4'b1011) begin errors++; $display("FAIL wd_ptr got %b exp 1011", o_busy); end
        i_req = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        int cnt [4] = '{0, 0, 0, 0};
        int cyc;
        bit done;
        do_reset();
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            for (int k = 0; k < 4; k++) i_req[k] = (cnt[k] < 6);
            tick();
            cyc++;
            checks++; if ($countones(~o_busy) > 1) begin errors++; $display("FAIL b2b_owners got %b exp at most one low", o_busy); end
            checks++; if (o_valid && o_err) begin errors++; $display("FAIL b2b_pulses got v=1 e=1 exp not both"); end
            if (o_valid) begin
                checks++; if ($isunknown(o_data) || o_data !== 8'(cnt[o_source])) begin
                    errors++; $display("FAIL b2b_data w%0d got %h exp %h", o_source, o_data, 8'(cnt[o_source]));
                end
                cnt[o_source]++;
            end
            i_data = 8'hzz;
            for (int k = 0; k < 4; k++) if (!o_busy[k]) i_data = 8'(cnt[k]);
            done = (cnt[0] == 6) && (cnt[1] == 6) && (cnt[2] == 6) && (cnt[3] == 6);
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (cnt[k] != 6) begin errors++; $display("FAIL b2b_count w%0d got %0d exp 6", k, cnt[k]); end
        end
        i_req  = 4'b0000;
        i_data = 8'h00;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_reset_mid_grant();
        test_withdraw();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_WRITERS  4  number of writer clients sharing the 8-bit data bus (2..8)
  HOLD_CYCLES  2  bus-idle cycles after every grant (>=1)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  i_clk  input  1  single clock, all logic on rising edge
  i_reset  input  1  reset, asynchronous, active-high
  i_req  input  N_WRITERS  per-writer bus request, held until granted
  i_data  input  8  shared bus, driven only by the granted writer
  o_busy  output  N_WRITERS  per-writer busy; low = that writer owns the bus this cycle
  o_data  output  8  captured transfer data
  o_valid  output  1  one-cycle pulse, o_data/o_source valid
  o_source  output  clog2(N_WRITERS)  index of writer that produced o_data
  o_err  output  1  one-cycle pulse on protocol violation
REQ-003 Clock and reset SHALL be i_clk and i_reset; one clock; reset asynchronous, active-high.

Function
REQ-004 FSM states SHALL be IDLE, GRANT, HOLD; no other encodings reachable.
REQ-005 All outputs SHALL be registered.
REQ-006 o_busy SHALL be all ones in every state except GRANT, where exactly one bit (winner w) is low.
REQ-007 IDLE, i_req nonzero in cycle c: winner w = first set bit of i_req searching upward from pointer p with wrap; state GRANT and o_busy[w]=0 in cycle c+1.
REQ-008 IDLE with i_req zero: remain IDLE, outputs unchanged except pulses cleared.
REQ-009 GRANT, cycle c+1, i_req[w]=1: capture i_data; cycle c+2 o_valid=1, o_data=captured value, o_source=w.
REQ-010 GRANT, i_req[w]=0 (writer withdrew): no capture, o_valid stays 0, o_err=1 in cycle c+2.
REQ-011 Leaving GRANT: o_busy all ones, p <= (w+1) mod N_WRITERS regardless of REQ-009/010, state HOLD.
REQ-012 HOLD SHALL last exactly HOLD_CYCLES cycles (down-counter), then IDLE; i_req ignored during HOLD.
REQ-013 Grant period per transfer SHALL be 2+HOLD_CYCLES cycles (IDLE, GRANT, HOLD).
REQ-014 o_valid and o_err SHALL be single-cycle pulses, never both high.
REQ-015 Requests from non-winners SHALL stay pending (busy high) with no loss; round-robin bounds wait to N_WRITERS-1 grants.
REQ-016 o_data and o_source SHALL hold last captured values between pulses.

Reset
REQ-017 On i_reset (asynchronous): state IDLE, o_busy all ones, o_data 0, o_source 0, o_valid 0, o_err 0, p 0, hold counter 0.
REQ-018 Reset mid-GRANT SHALL raise the granted busy bit immediately, with no o_valid or o_err produced.
REQ-019 First grant after reset release SHALL be evaluated no earlier than the first rising edge with i_reset low.

Structure
REQ-020 Shared package SHALL hold state enum (IDLE/GRANT/HOLD), data width 8, and pointer-width function.
REQ-021 Winner selection SHALL be a combinational sub-module rr_priority (inputs req vector, pointer; outputs winner index, any-valid).
REQ-022 Formal properties SHALL prove: state bounded, at most one o_busy bit low, busy low never two consecutive cycles, o_valid implies prior-cycle grant.

Verification (N_WRITERS=4, HOLD_CYCLES=2)
REQ-023 Reset, i_req=0100 with i_data=0x05 during grant -> o_busy=1011 for one cycle, next cycle o_valid=1, o_data=0x05, o_source=2.
REQ-024 i_req=1111 held from reset -> grants to 0,1,2,3,0 in order, o_busy low every 4 cycles.
REQ-025 p=1, i_req=1001 held -> grant order 3,0,3,0.
REQ-026 i_reset pulsed while o_busy=1101 -> o_busy=1111 same cycle, no o_valid, next grant from writer 0 if requested.
REQ-027 Writer 1 drops i_req during its GRANT -> o_err pulse, o_valid 0, p=2.
REQ-028 Four writer clients (counter max 5) on a tristate bus -> never two bus drivers, every count value delivered once per writer, no X on o_data.
